misc_alu_unit: RTL

Sequential execute unit for the miscellaneous ALU operations INC, DEC, SLT, SGT, LUI and HAM. It accepts one operation per request over a valid/ready handshake and returns the result plus a carry/borrow flag over a second valid/ready handshake. HAM (population count) is computed iteratively, one nibble per cycle, unless the fast option is compiled in. It sits behind the decode stage as the response side of the op/operand interface that the combinational op modules are driven through.

---
 rtl/misc_alu_pkg.sv | 21 ++
 rtl/misc_alu_pop4.sv | 9 +
 rtl/misc_alu_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/misc_alu_pkg.sv
// rtl/misc_alu_pkg.sv - opcode/state encodings and constants for misc_alu_unit
package misc_alu_pkg;

  typedef enum logic [2:0] {
    OP_INC = 3'd0,
    OP_DEC = 3'd1,
    OP_SLT = 3'd2,
    OP_SGT = 3'd3,
    OP_LUI = 3'd4,
    OP_HAM = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HAM_RUN = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  localparam int HAM_NIBBLES = 8;

endpackage

// File: rtl/misc_alu_pop4.sv
// rtl/misc_alu_pop4.sv - population count of one nibble
module misc_alu_pop4 (
  input  logic [3:0] nib,
  output logic [2:0] cnt
);

  assign cnt = {2'b00, nib[0]} + {2'b00, nib[1]} + {2'b00, nib[2]} + {2'b00, nib[3]};

endmodule

// File: rtl/misc_alu_unit.sv
// rtl/misc_alu_unit.sv - sequential INC/DEC/SLT/SGT/LUI/HAM execute unit
// MISC_ALU_HAM_FAST_EN selects a single-cycle HAM instead of the nibble-serial loop.
module misc_alu_unit
  import misc_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [15:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_flag,
  output logic        out_err
);

  state_e      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [31:0] result_q, result_d;
  logic        flag_q, flag_d;
  logic        err_q, err_d;
  logic        accept;
  logic [32:0] inc_sum;
  logic [32:0] dec_diff;
  logic [31:0] simple_res;
  logic        simple_flag;
  logic        simple_err;

`ifdef MISC_ALU_HAM_FAST_EN
  logic [2:0] nib_cnt [HAM_NIBBLES];
  logic [3:0] sum_l1 [4];
  logic [4:0] sum_l2 [2];
  logic [5:0] fast_pop;

  for (genvar g = 0; g < HAM_NIBBLES; g++) begin : g_pop
    misc_alu_pop4 u_pop4 (
      .nib (in_a[4*g +: 4]),
      .cnt (nib_cnt[g])
    );
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum_l1[i] = {1'b0, nib_cnt[2*i]} + {1'b0, nib_cnt[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      sum_l2[i] = {1'b0, sum_l1[2*i]} + {1'b0, sum_l1[2*i+1]};
    end
    fast_pop = {1'b0, sum_l2[0]} + {1'b0, sum_l2[1]};
  end
`else
  logic [31:0] shift_q, shift_d;
  logic [5:0]  acc_q, acc_d;
  logic [5:0]  acc_next;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  nib_pop;
  logic        is_ham;

  misc_alu_pop4 u_pop4 (
    .nib (shift_q[3:0]),
    .cnt (nib_pop)
  );

  assign acc_next = acc_q + {3'b000, nib_pop};
`endif

  // In reset the state is already IDLE, so readiness is a separate flop held low until the first edge.
  assign accept     = in_valid & rdy_q;
  assign in_ready   = rdy_q;
  assign out_valid  = (state_q == ST_RESP);
  assign out_result = result_q;
  assign out_flag   = flag_q;
  assign out_err    = err_q;

  always_comb begin
    inc_sum     = {1'b0, in_a} + 33'd1;
    dec_diff    = {1'b0, in_a} - 33'd1;
    simple_res  = '0;
    simple_flag = 1'b0;
    simple_err  = 1'b0;
`ifndef MISC_ALU_HAM_FAST_EN
    is_ham      = 1'b0;
`endif
    case (op_e'(in_op))
      OP_INC: begin
        simple_res  = inc_sum[31:0];
        simple_flag = inc_sum[32];
      end
      OP_DEC: begin
        simple_res  = dec_diff[31:0];
        simple_flag = dec_diff[32];
      end
      OP_SLT: simple_res = {31'd0, $signed(in_a) < $signed(in_b)};
      OP_SGT: simple_res = {31'd0, $signed(in_a) > $signed(in_b)};
      OP_LUI: simple_res = {in_imm, 16'h0000};
      OP_HAM: begin
`ifdef MISC_ALU_HAM_FAST_EN
        simple_res = {26'd0, fast_pop};
`else
        is_ham = 1'b1;
`endif
      end
      default: simple_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_d   = flag_q;
    err_d    = err_q;
`ifndef MISC_ALU_HAM_FAST_EN
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          result_d = simple_res;
          flag_d   = simple_flag;
          err_d    = simple_err;
          state_d  = ST_RESP;
`ifndef MISC_ALU_HAM_FAST_EN
          if (is_ham) begin
            shift_d = in_a;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_HAM_RUN;
          end
`endif
        end
      end
`ifndef MISC_ALU_HAM_FAST_EN
      ST_HAM_RUN: begin
        acc_d   = acc_next;
        shift_d = {4'h0, shift_q[31:4]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'(HAM_NIBBLES - 1)) begin
          result_d = {26'd0, acc_next};
          flag_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rdy_q    <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
    end
  end

`ifndef MISC_ALU_HAM_FAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

endmodule
